// File: rtl/piso_mux_sequencer_pkg.sv
// Shared types and constants for the parallel-in/serial-out select sequencer.
// State encodings: ST_IDLE=0, ST_SHIFT=1, ST_GAP=2; code 3 is never entered and decodes as idle.
package piso_mux_sequencer_pkg;

    localparam int DATA_W  = 8;
    localparam int SEL_W   = 3;
    localparam int GAP_W   = 4;
    localparam int GAP_MAX = 15;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } state_e;

    function automatic logic [SEL_W-1:0] start_sel(input bit msb_first);
        return msb_first ? {SEL_W{1'b1}} : {SEL_W{1'b0}};
    endfunction

    function automatic logic [SEL_W-1:0] last_sel(input bit msb_first);
        return msb_first ? {SEL_W{1'b0}} : {SEL_W{1'b1}};
    endfunction

endpackage

// File: rtl/piso_mux_sequencer_if.sv
// Word handshake, serial bit stream and select lines of the sequencer.
// master = upstream/downstream environment, slave = the sequencer itself.
interface piso_mux_sequencer_if;
    import piso_mux_sequencer_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              ser_ready;
    logic              ser_valid;
    logic              ser_out;
    logic [SEL_W-1:0]  sel;
    logic              frame_done;
    logic              busy;

    modport master (
        output in_valid, in_data, ser_ready,
        input  in_ready, ser_valid, ser_out, sel, frame_done, busy
    );

    modport slave (
        input  in_valid, in_data, ser_ready,
        output in_ready, ser_valid, ser_out, sel, frame_done, busy
    );

endinterface

// File: rtl/MUX_8_1.sv
// 8:1 single-bit multiplexer: y = d[s].
module MUX_8_1 (
    output logic       y,
    input  logic [2:0] s,
    input  logic [7:0] d
);

    // NOTE: a default arm keeps the case fully specified, so no latch is inferred.
    always_comb begin
        case (s)
            3'd0:    y = d[0];
            3'd1:    y = d[1];
            3'd2:    y = d[2];
            3'd3:    y = d[3];
            3'd4:    y = d[4];
            3'd5:    y = d[5];
            3'd6:    y = d[6];
            default: y = d[7];
        endcase
    end

endmodule

// File: rtl/sel_counter_3.sv
// 3-bit select counter with synchronous reset, load, enable and count direction.
// Wraps modulo 8 in either direction.
module sel_counter_3 (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [2:0] load_val,
    input  logic       en,
    input  logic       down,
    output logic [2:0] cnt
);

    // NOTE: clocked state uses <= so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= 3'd0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en) begin
            cnt <= down ? cnt - 3'd1 : cnt + 3'd1;
        end
    end

endmodule

// File: rtl/piso_mux_sequencer.sv
// Parallel-in/serial-out sequencer: captures a word, walks sel over all eight bit
// positions and presents MUX_8_1(sel, data_reg) as the serial bit, one per beat.
module piso_mux_sequencer
    import piso_mux_sequencer_pkg::*;
#(
    parameter bit          MSB_FIRST  = 1'b0,
    parameter int unsigned GAP_CYCLES = 1
) (
    input logic                 clk,
    input logic                 reset,
    piso_mux_sequencer_if.slave bus
);

    if (GAP_CYCLES > GAP_MAX) begin : g_gap_check
        $error("GAP_CYCLES must be in 0..15");
    end

    localparam logic [GAP_W-1:0] GAP_LOAD  = (GAP_CYCLES == 0) ? '0 : GAP_W'(GAP_CYCLES - 1);
    localparam logic [SEL_W-1:0] SEL_START = start_sel(MSB_FIRST);
    localparam logic [SEL_W-1:0] SEL_LAST  = last_sel(MSB_FIRST);

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   data_reg;
    logic [GAP_W-1:0]    gap_cnt_q, gap_cnt_d;
    logic [SEL_W-1:0]    sel;
    logic                accept;
    logic                sel_load;
    logic                sel_en;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            data_reg  <= '0;
            gap_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            gap_cnt_q <= gap_cnt_d;
            if (accept) begin
                data_reg <= bus.in_data;
            end
        end
    end

    always_comb begin
        state_d        = state_q;
        gap_cnt_d      = gap_cnt_q;
        accept         = 1'b0;
        sel_load       = 1'b0;
        sel_en         = 1'b0;
        bus.in_ready   = 1'b0;
        bus.ser_valid  = 1'b0;
        bus.frame_done = 1'b0;

        case (state_q)
            ST_SHIFT: begin
                bus.ser_valid = 1'b1;
                if (bus.ser_ready) begin
                    // Stepping past the last index wraps sel back to its start value.
                    sel_en = 1'b1;
                    if (sel == SEL_LAST) begin
                        bus.frame_done = ~reset;
                        if (GAP_CYCLES == 0) begin
                            state_d = ST_IDLE;
                        end else begin
                            state_d   = ST_GAP;
                            gap_cnt_d = GAP_LOAD;
                        end
                    end
                end
            end
            ST_GAP: begin
                if (gap_cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q - 1'b1;
                end
            end
            default: begin
                // Idle, and the unused code 3, which recovers as idle.
                bus.in_ready = 1'b1;
                state_d      = ST_IDLE;
                if (bus.in_valid) begin
                    accept   = 1'b1;
                    sel_load = 1'b1;
                    state_d  = ST_SHIFT;
                end
            end
        endcase
    end

    sel_counter_3 u_sel_counter (
        .clk      (clk),
        .reset    (reset),
        .load     (sel_load),
        .load_val (SEL_START),
        .en       (sel_en),
        .down     (MSB_FIRST),
        .cnt      (sel)
    );

    MUX_8_1 u_mux (
        .y (bus.ser_out),
        .s (sel),
        .d (data_reg)
    );

    assign bus.sel  = sel;
    assign bus.busy = (state_q == ST_SHIFT) || (state_q == ST_GAP);

endmodule
